// File: rtl/pll_lock_detect.sv
// Lock detector on the PLL output clock: counts CLK cycles per REF period, qualifies windows, and drives LOCK.
// Latency: a REF rise acts SYNC_STAGES+1 CLK edges after it happens; LOCK/LOCK_LOST are registered one edge after the deciding ref_rise.
// Backpressure: none; free-running status block with no handshake.
//
// Ports:
//   CLK        PLL output clock; all logic runs on its posedge
//   RST_N      synchronous active-low reset
//   REF        reference clock, asynchronous to CLK
//   LOCK       registered lock status
//   PERIOD     CLK cycles counted over the last complete REF period
//   LOCK_LOST  1-cycle pulse when LOCKED is left (sticky level with PLL_LD_STICKY_EN)
//   CLR_LOST   clears the sticky lost flag; ignored unless PLL_LD_STICKY_EN is defined
//
// Build option: define PLL_LD_STICKY_EN to turn LOCK_LOST into a sticky flag cleared by CLR_LOST.
module pll_lock_detect #(
    parameter int MULT        = 8,
    parameter int TOL         = 1,
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_CNT  = 2,
    parameter int CW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          REF,
    output logic          LOCK,
    output logic [CW-1:0] PERIOD,
    output logic          LOCK_LOST,
    input  logic          CLR_LOST
);

    localparam logic [CW-1:0] CNT_SAT = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW:0]   MULT_X  = (CW+1)'(MULT);
    localparam logic [CW:0]   TOL_X   = (CW+1)'(TOL);

    // Good/bad run counters only ever hold 0..N-1; reaching N is the transition itself.
    localparam int GW = (LOCK_CNT   > 1) ? $clog2(LOCK_CNT)   : 1;
    localparam int BW = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT) : 1;
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQ,
        ST_LOCKED
    } state_t;

    // ------------------------------------------------------------------
    // REF synchronizer and rising-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d_q;
    logic                   ref_rise;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_q   <= '0;
            sync_d_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], REF};
            sync_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign ref_rise = sync_q[SYNC_STAGES-1] & ~sync_d_q;

    // ------------------------------------------------------------------
    // Period counter. Saturation at all-ones doubles as the REF-stopped
    // marker, so the counter simply parks there while REF is absent.
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] period_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else if (ref_rise) begin
            period_q <= cnt_q;
            cnt_q    <= CNT_ONE;
        end else if (cnt_q != CNT_SAT) begin
            cnt_q    <= cnt_q + CNT_ONE;
        end
    end

    // Deviation from MULT in CW+1 bits so a small count never wraps to a
    // large unsigned value.
    logic [CW:0] cnt_x;
    logic [CW:0] dev;
    logic        window_good;
    logic        timeout;

    assign cnt_x = {1'b0, cnt_q};

    always_comb begin
        dev = '0;
        if (cnt_x >= MULT_X) begin
            dev = cnt_x - MULT_X;
        end else begin
            dev = MULT_X - cnt_x;
        end
    end

    // A saturated count is never a good window, even if ref_rise arrives
    // in the very cycle the counter hits all-ones.
    assign window_good = (cnt_q != CNT_SAT) && (dev <= TOL_X);
    assign timeout     = (cnt_q == CNT_SAT) && !ref_rise;

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic [BW-1:0] bad_q, bad_d;
    logic          lock_q, lock_d;
    logic          lost_q, lost_d;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            good_q  <= '0;
            bad_q   <= '0;
            lock_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            lock_q  <= lock_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        lock_d  = lock_q;
        lost_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // First rise after reset/timeout only opens a window; the
                // count it closes is partial and is not judged.
                if (ref_rise) begin
                    state_d = ST_ACQ;
                    good_d  = '0;
                    bad_d   = '0;
                end
            end

            ST_ACQ: begin
                if (ref_rise) begin
                    if (window_good) begin
                        if (good_q == GOOD_LAST) begin
                            state_d = ST_LOCKED;
                            lock_d  = 1'b1;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            good_d = good_q + GW'(1);
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    lock_d  = 1'b0;
                    good_d  = '0;
                    bad_d   = '0;
                end
            end

            ST_LOCKED: begin
                if (ref_rise) begin
                    if (window_good) begin
                        bad_d = '0;
                    end else if (bad_q == BAD_LAST) begin
                        state_d = ST_ACQ;
                        lock_d  = 1'b0;
                        lost_d  = 1'b1;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        bad_d = bad_q + BW'(1);
                    end
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    lock_d  = 1'b0;
                    lost_d  = 1'b1;
                    good_d  = '0;
                    bad_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                lock_d  = 1'b0;
                good_d  = '0;
                bad_d   = '0;
            end
        endcase
    end

    assign LOCK   = lock_q;
    assign PERIOD = period_q;

`ifdef PLL_LD_STICKY_EN
    // Sticky flag: a new loss event outranks a clear in the same cycle so
    // an event is never silently dropped.
    logic lost_sticky;
    logic unused_lost_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            lost_sticky <= 1'b0;
        end else if (lost_d) begin
            lost_sticky <= 1'b1;
        end else if (CLR_LOST) begin
            lost_sticky <= 1'b0;
        end
    end

    assign unused_lost_q = lost_q;
    assign LOCK_LOST     = lost_sticky;
`else
    logic unused_clr_lost;

    assign unused_clr_lost = CLR_LOST;
    assign LOCK_LOST       = lost_q;
`endif

endmodule

// File: tb/tb_pll_lock_detect.sv
module tb_pll_lock_detect;

    localparam int MULT       = 8;
    localparam int TOL        = 1;
    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_CNT = 2;
    localparam int SATV       = 255;

    localparam int M_IDLE   = 0;
    localparam int M_ACQ    = 1;
    localparam int M_LOCKED = 2;

    logic       CLK      = 1'b0;
    logic       RST_N    = 1'b0;
    logic       REF      = 1'b0;
    logic       CLR_LOST = 1'b0;
    logic       LOCK;
    logic       LOCK_LOST;
    logic [7:0] PERIOD;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    pll_lock_detect #(
        .MULT(MULT), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT),
        .CW(8), .SYNC_STAGES(2)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .REF(REF), .LOCK(LOCK),
        .PERIOD(PERIOD), .LOCK_LOST(LOCK_LOST), .CLR_LOST(CLR_LOST)
    );

    // ------------------------------------------------------------------
    // Reference model: timestamps of REF rises (edge numbers) rather than
    // a cycle counter; a rise sampled at edge E is acted on at edge E+2.
    // ------------------------------------------------------------------
    int         t = 0;
    bit         samp [0:1023];
    int         last_ts = 0;
    logic [7:0] m_period = 8'd0;
    bit         m_lock = 1'b0;
    bit         m_lost_p = 1'b0;
    bit         m_sticky = 1'b0;
    int         m_state = M_IDLE;
    int         m_good = 0;
    int         m_bad = 0;
    logic       exp_lost;

`ifdef PLL_LD_STICKY_EN
    assign exp_lost = m_sticky;
`else
    assign exp_lost = m_lost_p;
`endif

    always @(posedge CLK) begin
        int  elapsed;
        bit  rise;
        bit  good;
        t = t + 1;
        if (!RST_N) begin
            samp[t % 1024] = 1'b0;
            last_ts  = t + 1;
            m_period = 8'd0;
            m_lock   = 1'b0;
            m_lost_p = 1'b0;
            m_sticky = 1'b0;
            m_state  = M_IDLE;
            m_good   = 0;
            m_bad    = 0;
        end else begin
            samp[t % 1024] = REF;
            rise    = samp[(t - 2) % 1024] & ~samp[(t - 3) % 1024];
            elapsed = t - last_ts;
            if (elapsed > SATV) elapsed = SATV;
            m_lost_p = 1'b0;
            if (rise) begin
                good = (elapsed != SATV) && (elapsed - MULT <= TOL) && (MULT - elapsed <= TOL);
                m_period = 8'(elapsed);
                last_ts  = t;
                if (m_state == M_IDLE) begin
                    m_state = M_ACQ;
                    m_good  = 0;
                end else if (m_state == M_ACQ) begin
                    if (good) begin
                        m_good = m_good + 1;
                        if (m_good == LOCK_CNT) begin
                            m_state = M_LOCKED;
                            m_lock  = 1'b1;
                            m_good  = 0;
                            m_bad   = 0;
                        end
                    end else begin
                        m_good = 0;
                    end
                end else begin
                    if (good) begin
                        m_bad = 0;
                    end else begin
                        m_bad = m_bad + 1;
                        if (m_bad == UNLOCK_CNT) begin
                            m_state  = M_ACQ;
                            m_lock   = 1'b0;
                            m_lost_p = 1'b1;
                            m_good   = 0;
                            m_bad    = 0;
                        end
                    end
                end
            end else if (m_state != M_IDLE && elapsed == SATV) begin
                if (m_state == M_LOCKED) m_lost_p = 1'b1;
                m_state = M_IDLE;
                m_lock  = 1'b0;
                m_good  = 0;
                m_bad   = 0;
            end
            if (m_lost_p) m_sticky = 1'b1;
            else if (CLR_LOST) m_sticky = 1'b0;
        end
    end

    // One CLK cycle: inputs change at negedge, outputs observed 1 ns after posedge.
    task automatic cyc(input bit r);
        @(negedge CLK);
        REF = r;
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset(input int n);
        @(negedge CLK);
        RST_N    = 1'b0;
        REF      = 1'b0;
        CLR_LOST = 1'b0;
        repeat (n) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            RST_N = 1'b0;
            REF   = i[0];
            @(posedge CLK);
            #1;
            total++;
            if (LOCK !== 1'b0) begin
                bad++;
                $display("FAIL reset_lock cycle=%0d got=%b want=0", i, LOCK);
            end
            total++;
            if (PERIOD !== 8'd0) begin
                bad++;
                $display("FAIL reset_period cycle=%0d got=%0d want=0", i, PERIOD);
            end
            total++;
            if (LOCK_LOST !== 1'b0) begin
                bad++;
                $display("FAIL reset_lost cycle=%0d got=%b want=0", i, LOCK_LOST);
            end
        end
    endtask

    task automatic test_acquire();
        int c = 0;
        int first_lock = -1;
        int first_p8 = -1;
        @(negedge CLK);
        REF   = 1'b0;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        for (int w = 0; w < 7; w++) begin
            for (int k = 0; k < 8; k++) begin
                cyc(k < 4);
                total++;
                if ({LOCK, PERIOD, LOCK_LOST} !== {m_lock, m_period, exp_lost}) begin
                    bad++;
                    $display("FAIL acquire t=%0d got lock=%b period=%0d lost=%b want lock=%b period=%0d lost=%b",
                             t, LOCK, PERIOD, LOCK_LOST, m_lock, m_period, exp_lost);
                end
                if (LOCK === 1'b1 && first_lock < 0) first_lock = c;
                if (PERIOD === 8'd8 && first_p8 < 0) first_p8 = c;
                c++;
            end
        end
        // 5th REF rise sampled at cycle 32, acted on two edges later.
        total++;
        if (first_lock != 34) begin
            bad++;
            $display("FAIL acquire_lock_time got=%0d want=34", first_lock);
        end
        total++;
        if (first_p8 != 10) begin
            bad++;
            $display("FAIL acquire_period_time got=%0d want=10", first_p8);
        end
    endtask

    task automatic test_unlock();
        int pl [8] = '{8, 11, 8, 8, 11, 11, 8, 8};
        int lost_cycles = 0;
        bit early_drop = 1'b0;
        for (int w = 0; w < 8; w++) begin
            for (int k = 0; k < pl[w]; k++) begin
                cyc(k < pl[w] / 2);
                total++;
                if ({LOCK, PERIOD, LOCK_LOST} !== {m_lock, m_period, exp_lost}) begin
                    bad++;
                    $display("FAIL unlock t=%0d got lock=%b period=%0d lost=%b want lock=%b period=%0d lost=%b",
                             t, LOCK, PERIOD, LOCK_LOST, m_lock, m_period, exp_lost);
                end
                if (LOCK_LOST === 1'b1) lost_cycles++;
                if (w < 5 && LOCK !== 1'b1) early_drop = 1'b1;
            end
        end
        total++;
        if (early_drop) begin
            bad++;
            $display("FAIL unlock_single_bad got=dropped want=held");
        end
        total++;
        if (LOCK !== 1'b0) begin
            bad++;
            $display("FAIL unlock_final_lock got=%b want=0", LOCK);
        end
`ifndef PLL_LD_STICKY_EN
        total++;
        if (lost_cycles != 1) begin
            bad++;
            $display("FAIL unlock_pulse_count got=%0d want=1", lost_cycles);
        end
`endif
    endtask

    task automatic test_tolerance();
        int pa [5] = '{7, 9, 8, 7, 8};
        int pb [7] = '{7, 9, 10, 8, 7, 9, 8};
        apply_reset(2);
        for (int w = 0; w < 5; w++) begin
            for (int k = 0; k < pa[w]; k++) begin
                cyc(k < (pa[w] + 1) / 2);
                total++;
                if ({LOCK, PERIOD, LOCK_LOST} !== {m_lock, m_period, exp_lost}) begin
                    bad++;
                    $display("FAIL tol_a t=%0d got lock=%b period=%0d lost=%b want lock=%b period=%0d lost=%b",
                             t, LOCK, PERIOD, LOCK_LOST, m_lock, m_period, exp_lost);
                end
            end
            if (w == 3) begin
                total++;
                if (LOCK !== 1'b0) begin
                    bad++;
                    $display("FAIL tol_a_early got=%b want=0", LOCK);
                end
            end
        end
        total++;
        if (LOCK !== 1'b1) begin
            bad++;
            $display("FAIL tol_a_lock got=%b want=1", LOCK);
        end

        apply_reset(2);
        for (int w = 0; w < 8; w++) begin
            int p;
            p = (w < 7) ? pb[w] : 8;
            for (int k = 0; k < p; k++) begin
                cyc(k < (p + 1) / 2);
                total++;
                if ({LOCK, PERIOD, LOCK_LOST} !== {m_lock, m_period, exp_lost}) begin
                    bad++;
                    $display("FAIL tol_b t=%0d got lock=%b period=%0d lost=%b want lock=%b period=%0d lost=%b",
                             t, LOCK, PERIOD, LOCK_LOST, m_lock, m_period, exp_lost);
                end
            end
            if (w == 6) begin
                total++;
                if (LOCK !== 1'b0) begin
                    bad++;
                    $display("FAIL tol_b_restart got=%b want=0", LOCK);
                end
            end
        end
        total++;
        if (LOCK !== 1'b1) begin
            bad++;
            $display("FAIL tol_b_lock got=%b want=1", LOCK);
        end
    endtask

    task automatic test_ref_stop();
        int lost_cycles = 0;
        for (int k = 0; k < 300; k++) begin
            cyc(1'b0);
            total++;
            if ({LOCK, PERIOD, LOCK_LOST} !== {m_lock, m_period, exp_lost}) begin
                bad++;
                $display("FAIL stop t=%0d got lock=%b period=%0d lost=%b want lock=%b period=%0d lost=%b",
                         t, LOCK, PERIOD, LOCK_LOST, m_lock, m_period, exp_lost);
            end
            if (LOCK_LOST === 1'b1) lost_cycles++;
        end
        total++;
        if (LOCK !== 1'b0) begin
            bad++;
            $display("FAIL stop_lock got=%b want=0", LOCK);
        end
`ifndef PLL_LD_STICKY_EN
        total++;
        if (lost_cycles != 1) begin
            bad++;
            $display("FAIL stop_pulse_count got=%0d want=1", lost_cycles);
        end
`endif
        for (int w = 0; w < 7; w++) begin
            for (int k = 0; k < 8; k++) begin
                cyc(k < 4);
                total++;
                if ({LOCK, PERIOD, LOCK_LOST} !== {m_lock, m_period, exp_lost}) begin
                    bad++;
                    $display("FAIL relock t=%0d got lock=%b period=%0d lost=%b want lock=%b period=%0d lost=%b",
                             t, LOCK, PERIOD, LOCK_LOST, m_lock, m_period, exp_lost);
                end
            end
        end
        total++;
        if (LOCK !== 1'b1) begin
            bad++;
            $display("FAIL relock_lock got=%b want=1", LOCK);
        end
    endtask

    task automatic test_random();
        for (int w = 0; w < 160; w++) begin
            int p;
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 3) begin
                apply_reset(int'($urandom_range(1, 3)));
                total++;
                if ({LOCK, PERIOD, LOCK_LOST} !== {m_lock, m_period, exp_lost}) begin
                    bad++;
                    $display("FAIL rand_reset t=%0d got lock=%b period=%0d lost=%b want lock=%b period=%0d lost=%b",
                             t, LOCK, PERIOD, LOCK_LOST, m_lock, m_period, exp_lost);
                end
            end
            if (sel >= 3 && sel < 6) p = int'($urandom_range(250, 300));
            else if (sel < 70) p = int'($urandom_range(7, 9));
            else p = int'($urandom_range(4, 13));
            for (int k = 0; k < p; k++) begin
                CLR_LOST = ($urandom_range(0, 19) == 0);
                cyc((k < (p + 1) / 2) && (k < 6));
                total++;
                if ({LOCK, PERIOD, LOCK_LOST} !== {m_lock, m_period, exp_lost}) begin
                    bad++;
                    $display("FAIL random t=%0d p=%0d got lock=%b period=%0d lost=%b want lock=%b period=%0d lost=%b",
                             t, p, LOCK, PERIOD, LOCK_LOST, m_lock, m_period, exp_lost);
                end
            end
        end
        CLR_LOST = 1'b0;
    endtask

`ifdef PLL_LD_STICKY_EN
    task automatic test_sticky();
        int pl [9] = '{8, 11, 11, 8, 8, 8, 8, 8, 8};
        int pc [4] = '{11, 11, 8, 8};
        int high_cycles = 0;
        apply_reset(2);
        for (int w = 0; w < 16; w++) begin
            int p;
            p = (w < 7) ? 8 : pl[w - 7];
            for (int k = 0; k < p; k++) begin
                cyc(k < p / 2);
                total++;
                if ({LOCK, PERIOD, LOCK_LOST} !== {m_lock, m_period, exp_lost}) begin
                    bad++;
                    $display("FAIL sticky_run t=%0d got lock=%b period=%0d lost=%b want lock=%b period=%0d lost=%b",
                             t, LOCK, PERIOD, LOCK_LOST, m_lock, m_period, exp_lost);
                end
            end
        end
        total++;
        if ({LOCK, LOCK_LOST} !== 2'b11) begin
            bad++;
            $display("FAIL sticky_held got lock=%b lost=%b want lock=1 lost=1", LOCK, LOCK_LOST);
        end
        CLR_LOST = 1'b1;
        cyc(1'b1);
        CLR_LOST = 1'b0;
        total++;
        if (LOCK_LOST !== 1'b0) begin
            bad++;
            $display("FAIL sticky_clear got=%b want=0", LOCK_LOST);
        end
        for (int k = 1; k < 8; k++) cyc(k < 4);
        CLR_LOST = 1'b1;
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < pc[w]; k++) begin
                cyc(k < pc[w] / 2);
                total++;
                if ({LOCK, PERIOD, LOCK_LOST} !== {m_lock, m_period, exp_lost}) begin
                    bad++;
                    $display("FAIL sticky_coinc t=%0d got lock=%b period=%0d lost=%b want lock=%b period=%0d lost=%b",
                             t, LOCK, PERIOD, LOCK_LOST, m_lock, m_period, exp_lost);
                end
                if (LOCK_LOST === 1'b1) high_cycles++;
            end
        end
        CLR_LOST = 1'b0;
        total++;
        if (high_cycles != 1) begin
            bad++;
            $display("FAIL sticky_set_wins got=%0d want=1", high_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_acquire();
        test_unlock();
        test_tolerance();
        test_ref_stop();
        test_random();
`ifdef PLL_LD_STICKY_EN
        test_sticky();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
